// File: rtl/axi4_lite_m_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) between a single master
// and a single slave. ADDR_WIDTH and DATA_WIDTH must match the attached
// axi4_lite_m instance.
`timescale 1ns/1ps
interface axi4_lite_m_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;

  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;

  logic                    BVALID;
  logic                    BREADY;
  logic [1:0]              BRESP;

  logic                    ARVALID;
  logic                    ARREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;

  logic                    RVALID;
  logic                    RREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, input AWREADY,
    output WVALID, WDATA, WSTRB,    input WREADY,
    input  BVALID, BRESP,           output BREADY,
    output ARVALID, ARADDR, ARPROT, input ARREADY,
    input  RVALID, RDATA, RRESP,    output RREADY
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, output AWREADY,
    input  WVALID, WDATA, WSTRB,    output WREADY,
    output BVALID, BRESP,           input BREADY,
    input  ARVALID, ARADDR, ARPROT, output ARREADY,
    output RVALID, RDATA, RRESP,    input RREADY
  );
endinterface

// File: rtl/axi4_lite_m.sv
// Single-outstanding AXI4-Lite master. Turns one command (read or write)
// into the matching AXI channel handshakes and returns a one-cycle response.
// Optional response timeout: define AXI4_LITE_M_TIMEOUT_EN to build the
// watchdog counter (limit set by TIMEOUT_CYCLES); without it the FSM waits
// indefinitely for the slave.
`timescale 1ns/1ps
module axi4_lite_m #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi4_lite_m_if.master           m_axi
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axi4_lite_m: DATA_WIDTH must be 32 or 64, got %0d", DATA_WIDTH);
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi4_lite_m: TIMEOUT_CYCLES must be at least 1, got %0d", TIMEOUT_CYCLES);
  end

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0]              r_state;
  logic                    r_cmd_ready;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_resp;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [ADDR_WIDTH-1:0]   r_araddr;

  logic w_accept;
  logic w_aw_done;
  logic w_w_done;
  logic w_timeout;

  assign w_accept  = cmd_valid && r_cmd_ready;
  // A channel counts as done once its VALID has been dropped or is being
  // accepted this cycle, so AW and W may complete in either order.
  assign w_aw_done = !r_awvalid || m_axi.AWREADY;
  assign w_w_done  = !r_wvalid  || m_axi.WREADY;

`ifdef AXI4_LITE_M_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_busy;

  assign w_busy = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                  (r_state == ST_RD_REQ) || (r_state == ST_RD_RESP);
  // Fires during the last allowed waiting cycle so DONE follows exactly
  // TIMEOUT_CYCLES cycles after the transaction started.
  assign w_timeout = w_busy && (r_tmo_cnt == TMO_LAST);

  // Watchdog: restart on acceptance, count every cycle spent waiting on the slave
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (w_busy) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Transaction FSM: command capture, channel handshakes, response capture
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_araddr    <= '0;
    end else if (w_timeout) begin
      // Abandon the slave: drop every handshake and report SLVERR.
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_SLVERR;
      r_rsp_valid <= 1'b1;
      r_state     <= ST_DONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_REQ;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (r_awvalid && m_axi.AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid  && m_axi.WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi.BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= m_axi.BRESP;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          if (m_axi.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_axi.RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= m_axi.RDATA;
            r_rsp_resp  <= m_axi.RRESP;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;

  assign m_axi.AWVALID = r_awvalid;
  assign m_axi.AWADDR  = r_awaddr;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.WVALID  = r_wvalid;
  assign m_axi.WDATA   = r_wdata;
  assign m_axi.WSTRB   = r_wstrb;
  assign m_axi.BREADY  = r_bready;
  assign m_axi.ARVALID = r_arvalid;
  assign m_axi.ARADDR  = r_araddr;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_m.sv
// Directed bench for axi4_lite_m: the slave side is driven cycle by cycle
// from one initial block, outputs are checked on the falling clock edge.
// Timeout scenario depends on AXI4_LITE_M_TIMEOUT_EN (TIMEOUT_CYCLES=8).
`timescale 1ns/1ps
module tb_axi4_lite_m;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          ACLK    = 1'b0;
  logic          ARESETn = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW/8-1:0] cmd_wstrb = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  int checks   = 0;
  int failures = 0;

  axi4_lite_m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_m #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .m_axi     (bus)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (ARESETn) begin
      checks++;
      if ((bus.BREADY & bus.RREADY) !== 1'b0) begin
        failures++;
        $error("FAIL mon_bready_rready both high");
      end
      checks++;
      if ((bus.AWVALID & bus.ARVALID) !== 1'b0) begin
        failures++;
        $error("FAIL mon_awvalid_arvalid both high");
      end
      checks++;
      if ((cmd_ready & rsp_valid) !== 1'b0) begin
        failures++;
        $error("FAIL mon_cmd_ready_rsp_valid both high");
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  `define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

  task automatic cyc();
    @(negedge ACLK);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  initial begin
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    bus.BVALID  = 1'b0; bus.BRESP  = 2'b00;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0;
    bus.RDATA   = '0;   bus.RRESP  = 2'b00;

    // ---- reset state ----
    #1 ARESETn = 1'b0;
    #1;
    `CHK("rst_cmd_ready", cmd_ready, 0);
    `CHK("rst_awvalid", bus.AWVALID, 0);
    `CHK("rst_wvalid", bus.WVALID, 0);
    `CHK("rst_bready", bus.BREADY, 0);
    `CHK("rst_arvalid", bus.ARVALID, 0);
    `CHK("rst_rready", bus.RREADY, 0);
    `CHK("rst_rsp_valid", rsp_valid, 0);
    `CHK("rst_rsp_rdata", rsp_rdata, 0);
    `CHK("rst_rsp_resp", rsp_resp, 0);
    `CHK("rst_awaddr", bus.AWADDR, 0);
    `CHK("rst_wdata", bus.WDATA, 0);
    `CHK("rst_wstrb", bus.WSTRB, 0);
    `CHK("rst_araddr", bus.ARADDR, 0);
    cyc(); cyc();
    ARESETn = 1'b1;
    cyc();
    `CHK("post_rst_cmd_ready", cmd_ready, 1);
    `CHK("prot_aw", bus.AWPROT, 0);
    `CHK("prot_ar", bus.ARPROT, 0);

    // ---- write 0x10 <= DEADBEEF, zero-wait slave ----
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
    cyc();                                   // cycle 1
    cmd_valid = 1'b0;
    `CHK("w1_awvalid", bus.AWVALID, 1);
    `CHK("w1_wvalid", bus.WVALID, 1);
    `CHK("w1_awaddr", bus.AWADDR, 32'h10);
    `CHK("w1_wdata", bus.WDATA, 32'hDEADBEEF);
    `CHK("w1_wstrb", bus.WSTRB, 4'hF);
    `CHK("w1_cmd_ready", cmd_ready, 0);
    cyc();                                   // cycle 2
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    `CHK("w1_awvalid_drop", bus.AWVALID, 0);
    `CHK("w1_wvalid_drop", bus.WVALID, 0);
    `CHK("w1_bready", bus.BREADY, 1);
    bus.BVALID = 1'b1; bus.BRESP = 2'b00;
    cyc();                                   // cycle 3
    bus.BVALID = 1'b0;
    `CHK("w1_rsp_valid", rsp_valid, 1);
    `CHK("w1_rsp_resp", rsp_resp, 2'b00);
    `CHK("w1_rsp_rdata", rsp_rdata, 0);
    `CHK("w1_bready_drop", bus.BREADY, 0);
    `CHK("w1_cmd_ready_c3", cmd_ready, 0);
    cyc();                                   // cycle 4
    `CHK("w1_rsp_valid_1cyc", rsp_valid, 0);
    `CHK("w1_cmd_ready_c4", cmd_ready, 1);

    // ---- write with WREADY 3 cycles ahead of AWREADY ----
    issue(1'b1, 32'h44, 32'hA5A55A5A, 4'h3);
    cyc();                                   // cycle 1
    cmd_valid = 1'b0;
    `CHK("w2_awvalid", bus.AWVALID, 1);
    `CHK("w2_wvalid", bus.WVALID, 1);
    `CHK("w2_wstrb", bus.WSTRB, 4'h3);
    bus.WREADY = 1'b1;
    cyc();                                   // cycle 2
    bus.WREADY = 1'b0;
    `CHK("w2_wvalid_drop", bus.WVALID, 0);
    `CHK("w2_awvalid_hold2", bus.AWVALID, 1);
    `CHK("w2_bready_early2", bus.BREADY, 0);
    cyc();                                   // cycle 3
    `CHK("w2_awvalid_hold3", bus.AWVALID, 1);
    `CHK("w2_awaddr_stable", bus.AWADDR, 32'h44);
    `CHK("w2_bready_early3", bus.BREADY, 0);
    cyc();                                   // cycle 4
    `CHK("w2_awvalid_hold4", bus.AWVALID, 1);
    bus.AWREADY = 1'b1;
    cyc();                                   // cycle 5
    bus.AWREADY = 1'b0;
    `CHK("w2_awvalid_drop", bus.AWVALID, 0);
    `CHK("w2_bready", bus.BREADY, 1);
    bus.BVALID = 1'b1; bus.BRESP = 2'b10;
    cyc();                                   // cycle 6
    bus.BVALID = 1'b0;
    `CHK("w2_rsp_valid", rsp_valid, 1);
    `CHK("w2_rsp_resp", rsp_resp, 2'b10);
    `CHK("w2_rsp_rdata", rsp_rdata, 0);
    cyc();                                   // cycle 7
    `CHK("w2_cmd_ready", cmd_ready, 1);

    // ---- read 0x20, ARREADY 2 cycles late, stray RVALID ignored ----
    issue(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
    cyc();                                   // cycle 1
    cmd_valid = 1'b0;
    `CHK("r1_arvalid", bus.ARVALID, 1);
    `CHK("r1_araddr1", bus.ARADDR, 32'h20);
    `CHK("r1_rready_early", bus.RREADY, 0);
    `CHK("r1_awvalid_idle", bus.AWVALID, 0);
    bus.RVALID = 1'b1; bus.RDATA = 32'hBAD0BAD0; bus.RRESP = 2'b11;
    cyc();                                   // cycle 2
    bus.RVALID = 1'b0;
    `CHK("r1_arvalid_hold2", bus.ARVALID, 1);
    `CHK("r1_araddr2", bus.ARADDR, 32'h20);
    `CHK("r1_stray_rvalid", rsp_valid, 0);
    cyc();                                   // cycle 3
    `CHK("r1_araddr3", bus.ARADDR, 32'h20);
    bus.ARREADY = 1'b1;
    cyc();                                   // cycle 4
    bus.ARREADY = 1'b0;
    `CHK("r1_arvalid_drop", bus.ARVALID, 0);
    `CHK("r1_rready", bus.RREADY, 1);
    bus.RVALID = 1'b1; bus.RDATA = 32'h12345678; bus.RRESP = 2'b01;
    cyc();                                   // cycle 5
    bus.RVALID = 1'b0;
    `CHK("r1_rsp_valid", rsp_valid, 1);
    `CHK("r1_rsp_rdata", rsp_rdata, 32'h12345678);
    `CHK("r1_rsp_resp", rsp_resp, 2'b01);
    `CHK("r1_rready_drop", bus.RREADY, 0);
    cyc();                                   // cycle 6
    `CHK("r1_rsp_valid_1cyc", rsp_valid, 0);
    `CHK("r1_cmd_ready", cmd_ready, 1);

    // ---- read 0x60 with ARREADY never asserted ----
    issue(1'b0, 32'h60, 32'h0, 4'h0);
    cyc();                                   // cycle 1
    cmd_valid = 1'b0;
`ifdef AXI4_LITE_M_TIMEOUT_EN
    repeat (7) cyc();                        // cycle 8
    `CHK("to_arvalid_c8", bus.ARVALID, 1);
    `CHK("to_no_rsp_c8", rsp_valid, 0);
    cyc();                                   // cycle 9
    `CHK("to_rsp_valid", rsp_valid, 1);
    `CHK("to_rsp_resp", rsp_resp, 2'b10);
    `CHK("to_rsp_rdata", rsp_rdata, 0);
    `CHK("to_arvalid_drop", bus.ARVALID, 0);
    `CHK("to_rready", bus.RREADY, 0);
    cyc();                                   // cycle 10
    `CHK("to_cmd_ready", cmd_ready, 1);
`else
    repeat (19) cyc();                       // cycle 20
    `CHK("nt_arvalid_c20", bus.ARVALID, 1);
    `CHK("nt_araddr_c20", bus.ARADDR, 32'h60);
    `CHK("nt_no_rsp_c20", rsp_valid, 0);
    bus.ARREADY = 1'b1;
    cyc();                                   // cycle 21
    bus.ARREADY = 1'b0;
    `CHK("nt_rready", bus.RREADY, 1);
    bus.RVALID = 1'b1; bus.RDATA = 32'h55AA00FF; bus.RRESP = 2'b00;
    cyc();                                   // cycle 22
    bus.RVALID = 1'b0;
    `CHK("nt_rsp_valid", rsp_valid, 1);
    `CHK("nt_rsp_rdata", rsp_rdata, 32'h55AA00FF);
    `CHK("nt_rsp_resp", rsp_resp, 2'b00);
    cyc();                                   // cycle 23
    `CHK("nt_cmd_ready", cmd_ready, 1);
`endif

    // ---- reset pulse while ARVALID is high ----
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    cyc();                                   // cycle 1
    cmd_valid = 1'b0;
    `CHK("rp_arvalid", bus.ARVALID, 1);
    #2 ARESETn = 1'b0;
    #1;
    `CHK("rp_arvalid_async", bus.ARVALID, 0);
    `CHK("rp_araddr_async", bus.ARADDR, 0);
    `CHK("rp_cmd_ready_async", cmd_ready, 0);
    cyc();
    `CHK("rp_no_rsp_in_rst", rsp_valid, 0);
    ARESETn = 1'b1;
    cyc();
    `CHK("rp_cmd_ready_release", cmd_ready, 1);
    `CHK("rp_no_rsp_after", rsp_valid, 0);
    `CHK("rp_arvalid_after", bus.ARVALID, 0);

    // ---- new write after the reset pulse ----
    issue(1'b1, 32'h50, 32'h0BADF00D, 4'hC);
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
    cyc();                                   // cycle 1
    cmd_valid = 1'b0;
    `CHK("w3_awvalid", bus.AWVALID, 1);
    `CHK("w3_awaddr", bus.AWADDR, 32'h50);
    `CHK("w3_wdata", bus.WDATA, 32'h0BADF00D);
    cyc();                                   // cycle 2
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    `CHK("w3_bready", bus.BREADY, 1);
    bus.BVALID = 1'b1; bus.BRESP = 2'b01;
    cyc();                                   // cycle 3
    bus.BVALID = 1'b0;
    `CHK("w3_rsp_valid", rsp_valid, 1);
    `CHK("w3_rsp_resp", rsp_resp, 2'b01);
    cyc();                                   // cycle 4
    `CHK("w3_cmd_ready", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_m.md
AXI4_LITE_M -- requirements
Module: axi4_lite_m

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the data bus width; only 32 and 64 are legal, and any other value SHALL stop elaboration with an error message.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, giving the address bus width.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 256, giving the response timeout; it SHALL be used only when AXI4_LITE_M_TIMEOUT_EN is defined.
REQ-004 The module SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port ARESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have the command request ports: cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_addr in ADDR_WIDTH.
REQ-007 The module SHALL have the command write payload ports: cmd_wdata in DATA_WIDTH, cmd_wstrb in DATA_WIDTH/8.
REQ-008 The module SHALL have the response ports: rsp_valid out 1, rsp_rdata out DATA_WIDTH, rsp_resp out 2.
REQ-009 The module SHALL have the AW channel ports: AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH, AWPROT out 3 (tied 3'b000).
REQ-010 The module SHALL have the W channel ports: WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8.
REQ-011 The module SHALL have the B channel ports: BVALID in 1, BREADY out 1, BRESP in 2.
REQ-012 The module SHALL have the AR channel ports: ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH, ARPROT out 3 (tied 3'b000).
REQ-013 The module SHALL have the R channel ports: RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RRESP in 2.

Function
REQ-014 The state machine SHALL have the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on cmd_valid&&cmd_ready, and all cmd_* fields SHALL be registered at acceptance.
REQ-016 On an accepted write, the FSM SHALL go IDLE->WR_REQ, and AWVALID and WVALID SHALL both rise in the next cycle, driving the registered address, data and strobe.
REQ-017 In WR_REQ, AWVALID and WVALID SHALL each drop independently on their own handshake; the FSM SHALL enter WR_RESP once both handshakes are complete, in either order or in the same cycle.
REQ-018 In WR_RESP, BREADY SHALL be 1; on BVALID the FSM SHALL capture BRESP and go to DONE.
REQ-019 On an accepted read, the FSM SHALL go IDLE->RD_REQ with ARVALID asserted; on ARREADY it SHALL go to RD_RESP with RREADY=1; on RVALID it SHALL capture RDATA and RRESP and go to DONE.
REQ-020 In DONE, rsp_valid SHALL be 1 for exactly one cycle; rsp_rdata SHALL be the captured RDATA for a read and 0 for a write; rsp_resp SHALL be the captured BRESP or RRESP. The FSM SHALL then return to IDLE.
REQ-021 Once asserted, any VALID SHALL remain high, with its payload stable, until the matching READY is sampled high.
REQ-022 BREADY SHALL be 0 outside WR_RESP and RREADY SHALL be 0 outside RD_RESP; BVALID or RVALID arriving in any other state SHALL be ignored.
REQ-023 Minimum latency with zero-wait-state READY/VALID SHALL be: accept at cycle 0, VALID at cycle 1, response handshake at cycle 2, rsp_valid at cycle 3. The next command SHALL be accepted no earlier than cycle 4.

Reset
REQ-024 Asserting ARESETn=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE and force all of AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready, rsp_rdata, rsp_resp, AWADDR, WDATA, WSTRB and ARADDR to 0.
REQ-025 Reset asserted mid-transaction SHALL abandon that transaction with no rsp_valid; cmd_ready SHALL be 1 from the first clock edge after ARESETn returns to 1.

Configuration
REQ-026 With AXI4_LITE_M_TIMEOUT_EN defined, a counter SHALL clear at command acceptance and increment every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP. When it reaches TIMEOUT_CYCLES, the FSM SHALL drop all VALID/READY outputs and enter DONE with rsp_resp=2'b10 (SLVERR) and rsp_rdata=0.
REQ-027 Without AXI4_LITE_M_TIMEOUT_EN, no counter SHALL be built and the FSM SHALL wait indefinitely in any state.

Verification
REQ-028 A write to 0x10 of 0xDEADBEEF with strb 0xF, with AWREADY, WREADY and BVALID all immediate, SHALL produce AWADDR=0x10 and WDATA=0xDEADBEEF at cycle 1, and rsp_valid with rsp_resp=00 at cycle 3.
REQ-029 A write where WREADY arrives 3 cycles before AWREADY SHALL drop WVALID after the W handshake, keep AWVALID high until AWREADY, and assert BREADY only after both handshakes.
REQ-030 A read of 0x20 with ARREADY delayed 2 cycles and RDATA=0x12345678, RRESP=01 SHALL produce rsp_rdata=0x12345678 and rsp_resp=01, with ARADDR stable throughout the wait.
REQ-031 ARESETn pulsed low while ARVALID=1 SHALL drop ARVALID without waiting for a clock edge, produce no rsp_valid, and allow a new command to be accepted after release.
REQ-032 With AXI4_LITE_M_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, a read with ARREADY held at 0 SHALL produce rsp_valid with rsp_resp=10 and rsp_rdata=0 after 8 cycles in RD_REQ.
